// File: rtl/cache_pkg.sv
// cache_pkg: controller state type and address-split widths shared with the cache decoder.
package cache_pkg;
   typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_FILL, WRITE, RESPOND} cache_ctrl_state_t;

   function automatic int offset_bits(int words_per_block, int word_bits);
      return $clog2(words_per_block) + $clog2(word_bits / 8);
   endfunction

   function automatic int set_bits(int word_capacity, int words_per_block, int way_count);
      return $clog2(word_capacity / (words_per_block * way_count));
   endfunction

   function automatic int tag_bits(int addr_bits, int word_capacity, int words_per_block,
                                   int way_count, int word_bits);
      return addr_bits - offset_bits(words_per_block, word_bits)
             - set_bits(word_capacity, words_per_block, way_count);
   endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: per-set round-robin victim pointers, presented as a one-hot way.
module cache_victim_sel import cache_pkg::*; #(
   parameter int SETS = 1,
   parameter int WAYS = 1,
   parameter int SIW  = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [SIW-1:0]  set_idx,
   input  logic            advance,
   output logic [WAYS-1:0] way_oh
);
   localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1;

   logic [VW-1:0] ptr_q [SETS];
   logic [VW-1:0] ptr_d [SETS];

   always_comb begin
      ptr_d = ptr_q;
      if (advance)
         ptr_d[set_idx] = (ptr_q[set_idx] == VW'(WAYS - 1)) ? '0 : ptr_q[set_idx] + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ptr_q <= '{default: '0};
      else ptr_q <= ptr_d;

   assign way_oh = WAYS'(1) << ptr_q[set_idx];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: read-only cache sequencer; lookup, burst refill on miss,
// round-robin victim write, then re-lookup to return the word.
module cache_controller import cache_pkg::*; #(
   parameter int WORD_CAPACITY   = 8,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int WAY_COUNT       = 1,
   parameter int ADDR_BITS       = 32,
   parameter int WORD_BITS       = 32
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic                                     req_valid,
   input  logic [ADDR_BITS-1:0]                     req_addr,
   output logic                                     req_ready,
   output logic                                     rsp_valid,
   output logic [WORD_BITS-1:0]                     rsp_word,
   output logic [ADDR_BITS-1:0]                     cache_address,
   input  logic [WAY_COUNT-1:0]                     cache_hits,
   input  logic [WORD_BITS-1:0]                     cache_rd_word,
   output logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] cache_wr_block,
   output logic [WAY_COUNT-1:0]                     cache_wr_ens,
   output logic                                     mem_req_valid,
   input  logic                                     mem_req_ready,
   output logic [ADDR_BITS-1:0]                     mem_addr,
   input  logic                                     mem_rsp_valid,
   input  logic [WORD_BITS-1:0]                     mem_rsp_word
);
   localparam int OFS  = offset_bits(WORDS_PER_BLOCK, WORD_BITS);
   localparam int SB   = set_bits(WORD_CAPACITY, WORDS_PER_BLOCK, WAY_COUNT);
   localparam int SETS = 1 << SB;
   localparam int SIW  = SB > 0 ? SB : 1;
   localparam int CW   = $clog2(WORDS_PER_BLOCK);

   cache_ctrl_state_t                         state_q, state_d;
   logic [ADDR_BITS-1:0]                      addr_q, addr_d;
   logic [WORD_BITS-1:0]                      rsp_word_q, rsp_word_d;
   logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] fill_q, fill_d;
   logic [CW-1:0]                             cnt_q, cnt_d;
   logic [SIW-1:0]                            set_idx;
   logic [WAY_COUNT-1:0]                      victim_oh;
   logic                                      hit;

   assign hit     = |cache_hits;
   assign set_idx = (SB > 0) ? SIW'(addr_q >> OFS) : '0;

   cache_victim_sel #(.SETS(SETS), .WAYS(WAY_COUNT), .SIW(SIW)) u_victim (
      .clk     (clk),
      .reset_n (reset_n),
      .set_idx (set_idx),
      .advance (state_q == WRITE),
      .way_oh  (victim_oh)
   );

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rsp_word_q <= '0;
         fill_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rsp_word_q <= rsp_word_d;
         fill_q     <= fill_d;
         cnt_q      <= cnt_d;
      end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (req_valid) state_d = LOOKUP;
         LOOKUP:   state_d = hit ? RESPOND : MEM_REQ;
         MEM_REQ:  if (mem_req_ready) state_d = MEM_FILL;
         MEM_FILL: if (mem_rsp_valid && cnt_q == CW'(WORDS_PER_BLOCK - 1)) state_d = WRITE;
         WRITE:    state_d = LOOKUP;
         RESPOND:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d     = (state_q == IDLE && req_valid) ? req_addr : addr_q;
      rsp_word_d = (state_q == LOOKUP && hit) ? cache_rd_word : rsp_word_q;
      fill_d     = fill_q;
      cnt_d      = (state_q == MEM_REQ && mem_req_ready) ? '0 : cnt_q;
      if (state_q == MEM_FILL && mem_rsp_valid) begin
         fill_d[cnt_q] = mem_rsp_word;
         cnt_d         = cnt_q + 1'b1;
      end
   end

   always_comb begin
      req_ready     = state_q == IDLE;
      rsp_valid     = state_q == RESPOND;
      mem_req_valid = state_q == MEM_REQ;
      cache_wr_ens  = (state_q == WRITE) ? victim_oh : '0;
   end

   assign rsp_word       = rsp_word_q;
   assign cache_address  = addr_q;
   assign cache_wr_block = fill_q;
   assign mem_addr       = {addr_q[ADDR_BITS-1:OFS], {OFS{1'b0}}};

   // The datapath resolves multiple hits to the lowest way, but it signals a broken cache.
   a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == LOOKUP) |-> $onehot0(cache_hits));
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: 2-way, single-set configuration with a behavioural cache,
// a memory responder and a transaction-level reference model.
module tb_cache_controller;
   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              req_valid = 1'b0;
   logic [31:0]       req_addr = '0;
   logic              req_ready, rsp_valid;
   logic [31:0]       rsp_word, cache_address, mem_addr;
   logic [1:0]        cache_hits, cache_wr_ens;
   logic [31:0]       cache_rd_word;
   logic [127:0]      cache_wr_block;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic              mem_rsp_valid = 1'b0;
   logic [31:0]       mem_rsp_word = '0;

   cache_controller #(.WORD_CAPACITY(8), .WORDS_PER_BLOCK(4), .WAY_COUNT(2),
                      .ADDR_BITS(32), .WORD_BITS(32)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_word(rsp_word),
      .cache_address(cache_address), .cache_hits(cache_hits), .cache_rd_word(cache_rd_word),
      .cache_wr_block(cache_wr_block), .cache_wr_ens(cache_wr_ens),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_word(mem_rsp_word)
   );

   always #5 clk = ~clk;

   // Cache datapath stand-in: one set, two ways, tag = address[31:4].
   logic        cv [2] = '{1'b0, 1'b0};
   logic [27:0] ct [2];
   logic [31:0] cd [2][4];

   always_comb begin
      cache_hits    = '0;
      cache_rd_word = '0;
      for (int w = 1; w >= 0; w--)
         if (cv[w] && ct[w] == cache_address[31:4]) begin
            cache_hits[w] = 1'b1;
            cache_rd_word = cd[w][cache_address[3:2]];
         end
   end

   always @(posedge clk)
      for (int w = 0; w < 2; w++)
         if (cache_wr_ens[w]) begin
            cv[w] <= 1'b1;
            ct[w] <= cache_address[31:4];
            for (int k = 0; k < 4; k++) cd[w][k] <= cache_wr_block[k*32 +: 32];
         end

   int n_chk = 0, n_fail = 0, wr_pulses = 0;

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_val(logic [31:0] blk, int k);
      return 32'hA0 + k + ((blk >> 4) - 1) * 32'h100;
   endfunction

   // Reference model: resident tags per way plus the round-robin pointer.
   logic        mvalid [2] = '{1'b0, 1'b0};
   logic [27:0] mtag [2];
   int          mptr = 0;

   bit          exp_miss = 1'b0;
   int          exp_way = 0;
   logic [31:0] exp_word = '0, exp_mem_addr = '0;
   logic [1:0]  exp_wr = '0;
   logic [127:0] exp_blk = '0;

   bit busy = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         busy = 1'b0;
         chk("rst_req_ready", req_ready, 1);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_word", rsp_word, 0);
         chk("rst_mem_req_valid", mem_req_valid, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_wr_ens", cache_wr_ens, 0);
         chk("rst_cache_address", cache_address, 0);
      end else begin
         chk("req_ready", req_ready, !busy);
         if (rsp_valid) begin
            chk("rsp_only_when_busy", busy, 1);
            chk("rsp_word_model", rsp_word, exp_word);
         end
         if (mem_req_valid) begin
            chk("mem_req_on_miss", exp_miss, 1);
            chk("mem_addr", mem_addr, exp_mem_addr);
         end
         if (cache_wr_ens != 0) begin
            wr_pulses++;
            chk("wr_ens", cache_wr_ens, exp_wr);
            chk("wr_block", cache_wr_block, exp_blk);
         end
         busy = busy ? !rsp_valid : req_valid;
      end
   end

   task automatic do_req(input logic [31:0] a, input int rwait, input int gap, input int abort_beat,
                         input bit stray, input bit lit_miss, input int lit_way,
                         input int lit_lat, input logic [31:0] lit_word);
      int n, beat, g, rw, wr0, lat;
      bit fill, got, ab;
      logic [31:0] blk, got_word;
      blk = a & ~32'hF;
      exp_miss = 1'b1;
      exp_way  = mptr;
      for (int w = 0; w < 2; w++)
         if (exp_miss && mvalid[w] && mtag[w] == a[31:4]) begin
            exp_miss = 1'b0;
            exp_way  = w;
         end
      chk("model_miss", exp_miss, lit_miss);
      if (lit_miss) chk("model_way", exp_way, lit_way);
      exp_word     = mem_val(blk, int'(a[3:2]));
      exp_mem_addr = blk;
      exp_wr       = 2'(1 << exp_way);
      for (int k = 0; k < 4; k++) exp_blk[k*32 +: 32] = mem_val(blk, k);
      wr0 = wr_pulses;
      req_valid = 1'b1;
      req_addr  = a;
      n = 0; beat = 0; g = 0; rw = rwait; lat = 0;
      fill = 1'b0; got = 1'b0; ab = 1'b0; got_word = '0;
      while (!got && !ab && n < 200) begin
         @(posedge clk); #1;
         n++;
         req_valid     = 1'b0;
         req_addr      = 32'hDEAD_BEE0;
         mem_rsp_valid = 1'b0;
         if (rsp_valid) begin
            got = 1'b1;
            lat = n;
            got_word = rsp_word;
         end
         if (fill) begin
            if (g > 0) g--;
            else begin
               if (beat == abort_beat) begin
                  reset_n = 1'b0;
                  ab = 1'b1;
               end
               mem_rsp_valid = 1'b1;
               mem_rsp_word  = mem_val(blk, beat);
               beat++;
               g = gap;
               fill = beat < 4;
            end
            if (stray) begin
               req_valid = 1'b1;
               req_addr  = 32'h14;
            end
         end
         if (mem_req_valid) begin
            mem_req_ready = (rw == 0);
            if (rw == 0) begin
               fill = 1'b1; beat = 0; g = 0;
            end else rw--;
         end else mem_req_ready = 1'b0;
      end
      if (ab) begin
         mem_rsp_valid = 1'b0;
         repeat (2) @(posedge clk);
         #1 reset_n = 1'b1;
         mptr = 0;
         chk("abort_no_write", wr_pulses, wr0);
      end else begin
         chk("rsp_seen", got, 1);
         chk("latency", lat, lit_lat);
         chk("rsp_word", got_word, lit_word);
         chk("wr_pulse_count", wr_pulses - wr0, exp_miss);
         if (exp_miss) begin
            mvalid[exp_way] = 1'b1;
            mtag[exp_way]   = a[31:4];
            mptr            = (mptr + 1) % 2;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int wr0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      //      addr      rw gap abort stray miss way lat word
      do_req(32'h10,   0, 0,  -1,  0,    1,   0,  9, 32'hA0);
      do_req(32'h14,   0, 0,  -1,  0,    0,   0,  2, 32'hA1);
      do_req(32'h20,   0, 0,  -1,  0,    1,   1,  9, 32'h1A0);
      do_req(32'h30,   0, 0,  -1,  0,    1,   0,  9, 32'h2A0);
      do_req(32'h18,   0, 0,  -1,  0,    1,   1,  9, 32'hA2);
      do_req(32'h44,   5, 2,  -1,  0,    1,   0, 20, 32'h3A1);
      do_req(32'h50,   0, 0,   2,  0,    1,   1,  0, 32'h0);
      do_req(32'h50,   0, 0,  -1,  0,    1,   0,  9, 32'h4A0);
      wr0 = wr_pulses;
      mem_rsp_valid = 1'b1;
      mem_rsp_word  = 32'hBAD0_0000;
      repeat (3) @(posedge clk);
      #1 mem_rsp_valid = 1'b0;
      chk("idle_stray_no_write", wr_pulses, wr0);
      do_req(32'h1C,   0, 0,  -1,  0,    0,   1,  2, 32'hA3);
      do_req(32'h60,   0, 0,  -1,  1,    1,   1,  9, 32'h5A0);
      do_req(32'h64,   0, 0,  -1,  0,    0,   1,  2, 32'h5A1);
      do_req(32'h14,   0, 0,  -1,  0,    1,   0,  9, 32'hA1);
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
